// File: rtl/br_predict.sv
// IF-stage branch predictor: direct-mapped 2-bit counter table plus BTB, with a
// two-stage prediction pipe that is checked against the EX-stage resolution.
module br_predict #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc_IF,
    input  logic            stall_IF_ID,
    input  logic            stall_ID_EX,
    input  logic            flow_instr_ID_EX,
    input  logic            jmp_ID_EX,
    input  logic            taken_ID_EX,
    input  logic [PC_W-1:0] tgt_ID_EX,
    input  logic [PC_W-1:0] pc_ID_EX,
    output logic            pred_taken_IF,
    output logic [PC_W-1:0] pred_tgt_IF,
    output logic            mispredict_EX,
    output logic [PC_W-1:0] redirect_pc_EX
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;

    logic [ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]   tag_reg [ENTRIES];
    logic [PC_W-1:0]    tgt_reg [ENTRIES];
    logic [1:0]         ctr_reg [ENTRIES];

    logic            id_taken_reg, ex_taken_reg;
    logic [PC_W-1:0] id_tgt_reg, ex_tgt_reg;

    // Fetch-side lookup
    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_hit;

    assign lookup_idx    = pc_IF[IDX_W-1:0];
    assign lookup_hit    = valid_reg[lookup_idx] && (tag_reg[lookup_idx] == pc_IF[PC_W-1:IDX_W]);
    assign pred_taken_IF = lookup_hit && ctr_reg[lookup_idx][1];
    assign pred_tgt_IF   = pred_taken_IF ? tgt_reg[lookup_idx] : '0;

    // EX-side resolution check
    always_comb begin
        mispredict_EX  = 1'b0;
        redirect_pc_EX = '0;
        if (!stall_ID_EX) begin
            if (flow_instr_ID_EX && taken_ID_EX &&
                (!ex_taken_reg || (ex_tgt_reg != tgt_ID_EX))) begin
                mispredict_EX  = 1'b1;
                redirect_pc_EX = tgt_ID_EX;
            end else if ((flow_instr_ID_EX && !taken_ID_EX && ex_taken_reg) ||
                         (!flow_instr_ID_EX && ex_taken_reg)) begin
                mispredict_EX  = 1'b1;
                redirect_pc_EX = pc_ID_EX + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_taken_reg <= 1'b0;
            id_tgt_reg   <= '0;
            ex_taken_reg <= 1'b0;
            ex_tgt_reg   <= '0;
        end else if (mispredict_EX) begin
            id_taken_reg <= 1'b0;
            id_tgt_reg   <= '0;
            ex_taken_reg <= 1'b0;
            ex_tgt_reg   <= '0;
        end else begin
            if (!stall_IF_ID) begin
                id_taken_reg <= pred_taken_IF;
                id_tgt_reg   <= pred_tgt_IF;
            end
            if (!stall_ID_EX) begin
                ex_taken_reg <= id_taken_reg;
                ex_tgt_reg   <= id_tgt_reg;
            end
        end
    end

    // Training decode for the entry addressed by the EX instruction
    logic [IDX_W-1:0] upd_idx;
    logic             upd_hit;
    logic             do_train, do_alloc, do_inval;
    logic [1:0]       ctr_next;

    assign upd_idx = pc_ID_EX[IDX_W-1:0];
    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == pc_ID_EX[PC_W-1:IDX_W]);

    always_comb begin
        do_train = !stall_ID_EX && flow_instr_ID_EX && upd_hit;
        do_alloc = !stall_ID_EX && flow_instr_ID_EX && !upd_hit && taken_ID_EX;
        do_inval = !stall_ID_EX && !flow_instr_ID_EX && ex_taken_reg && upd_hit;
        ctr_next = ctr_reg[upd_idx];
        if (taken_ID_EX) begin
            if (ctr_reg[upd_idx] != 2'b11) ctr_next = ctr_reg[upd_idx] + 2'd1;
        end else begin
            if (ctr_reg[upd_idx] != 2'b00) ctr_next = ctr_reg[upd_idx] - 2'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic sel;
            assign sel = (upd_idx == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    tag_reg[gi]   <= '0;
                    tgt_reg[gi]   <= '0;
                    ctr_reg[gi]   <= 2'b01;
                end else if (sel) begin
                    if (do_train) begin
                        ctr_reg[gi] <= ctr_next;
                        if (taken_ID_EX) tgt_reg[gi] <= tgt_ID_EX;
                    end else if (do_alloc) begin
                        valid_reg[gi] <= 1'b1;
                        tag_reg[gi]   <= pc_ID_EX[PC_W-1:IDX_W];
                        tgt_reg[gi]   <= tgt_ID_EX;
                        ctr_reg[gi]   <= jmp_ID_EX ? 2'b11 : 2'b10;
                    end else if (do_inval) begin
                        valid_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_br_predict.sv
// Directed bench for br_predict: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them against the live outputs.
module tb_br_predict;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_IF;
    logic        stall_IF_ID, stall_ID_EX;
    logic        flow_instr_ID_EX, jmp_ID_EX, taken_ID_EX;
    logic [15:0] tgt_ID_EX, pc_ID_EX;
    logic        pred_taken_IF;
    logic [15:0] pred_tgt_IF;
    logic        mispredict_EX;
    logic [15:0] redirect_pc_EX;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        pt;
        logic [15:0] ptg;
        logic        mis;
        logic [15:0] red;
    } exp_t;

    exp_t exp_q[$];

    br_predict #(.PC_W(16), .IDX_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_IF            (pc_IF),
        .stall_IF_ID      (stall_IF_ID),
        .stall_ID_EX      (stall_ID_EX),
        .flow_instr_ID_EX (flow_instr_ID_EX),
        .jmp_ID_EX        (jmp_ID_EX),
        .taken_ID_EX      (taken_ID_EX),
        .tgt_ID_EX        (tgt_ID_EX),
        .pc_ID_EX         (pc_ID_EX),
        .pred_taken_IF    (pred_taken_IF),
        .pred_tgt_IF      (pred_tgt_IF),
        .mispredict_EX    (mispredict_EX),
        .redirect_pc_EX   (redirect_pc_EX)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are sampled on the falling edge, well away from posedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pred_taken_IF !== e.pt || pred_tgt_IF !== e.ptg ||
                    mispredict_EX !== e.mis || redirect_pc_EX !== e.red) begin
                    failures++;
                    $display("FAIL %s: got pt=%0b tgt=%h mis=%0b red=%h, want pt=%0b tgt=%h mis=%0b red=%h",
                             e.name, pred_taken_IF, pred_tgt_IF, mispredict_EX, redirect_pc_EX,
                             e.pt, e.ptg, e.mis, e.red);
                end else begin
                    $display("ok   %s: pt=%0b tgt=%h mis=%0b red=%h",
                             e.name, pred_taken_IF, pred_tgt_IF, mispredict_EX, redirect_pc_EX);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // One cycle: drive inputs, queue expectation, optionally assert reset mid-cycle
    task automatic cyc(input string nm, input logic [15:0] pcif, input logic sif, input logic sex,
                       input logic fl, input logic jp, input logic tk, input logic [15:0] tg,
                       input logic [15:0] pcx, input logic ept, input logic [15:0] eptg,
                       input logic emis, input logic [15:0] ered, input logic rst_mid);
        exp_t e;
        pc_IF            = pcif;
        stall_IF_ID      = sif;
        stall_ID_EX      = sex;
        flow_instr_ID_EX = fl;
        jmp_ID_EX        = jp;
        taken_ID_EX      = tk;
        tgt_ID_EX        = tg;
        pc_ID_EX         = pcx;
        e.name = nm; e.pt = ept; e.ptg = eptg; e.mis = emis; e.red = ered;
        exp_q.push_back(e);
        if (rst_mid) begin
            @(negedge clk);
            #2;
            rst_n = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc("reset",              16'h0023, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        rst_n = 1'b1;
        cyc("lookup_cold",        16'h0023, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("br_first_taken",     16'h0023, 0,0, 1,0,1,16'h0040,16'h0023, 0,16'h0000,1,16'h0040, 0);
        cyc("br_alloc_lookup",    16'h0023, 0,0, 0,0,0,16'h0000,16'h0000, 1,16'h0040,0,16'h0000, 0);
        cyc("fill_a",             16'h0000, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("br_nt_p1",           16'h0000, 0,0, 1,0,0,16'h0000,16'h0023, 0,16'h0000,1,16'h0024, 0);
        cyc("br_nt_p0",           16'h0023, 0,0, 1,0,0,16'h0000,16'h0023, 0,16'h0000,0,16'h0000, 0);
        cyc("br_predict_nt",      16'h0023, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("br_taken_from_00",   16'h0000, 0,0, 1,0,1,16'h0040,16'h0023, 0,16'h0000,1,16'h0040, 0);
        cyc("br_ctr_01_nt",       16'h0023, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("jmp_alloc",          16'h0000, 0,0, 1,1,1,16'h0200,16'h0105, 0,16'h0000,1,16'h0200, 0);
        cyc("jmp_lookup",         16'h0105, 0,0, 0,0,0,16'h0000,16'h0000, 1,16'h0200,0,16'h0000, 0);
        cyc("jmp_nt_p0",          16'h0000, 0,0, 1,1,0,16'h0000,16'h0105, 0,16'h0000,0,16'h0000, 0);
        cyc("jmp_new_tgt",        16'h0105, 0,0, 1,1,1,16'h0300,16'h0105, 1,16'h0200,1,16'h0300, 0);
        cyc("jmp_tgt_updated",    16'h0105, 0,0, 0,0,0,16'h0000,16'h0000, 1,16'h0300,0,16'h0000, 0);
        cyc("fill_b",             16'h0000, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("jmp_correct",        16'h0000, 0,0, 1,1,1,16'h0300,16'h0105, 0,16'h0000,0,16'h0000, 0);
        cyc("alias_alloc",        16'h0000, 0,0, 1,0,1,16'h0050,16'h0013, 0,16'h0000,1,16'h0050, 0);
        cyc("alias_tag_miss",     16'h0023, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("alias_hit",          16'h0013, 0,0, 0,0,0,16'h0000,16'h0000, 1,16'h0050,0,16'h0000, 0);
        cyc("fill_c",             16'h0000, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("alias_nonbranch",    16'h0013, 0,0, 0,0,0,16'h0000,16'h0013, 1,16'h0050,1,16'h0014, 0);
        cyc("alias_invalidated",  16'h0013, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("stall_setup",        16'h0105, 0,0, 0,0,0,16'h0000,16'h0000, 1,16'h0300,0,16'h0000, 0);
        cyc("fill_d",             16'h0000, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("stall_hold",         16'h0000, 0,1, 1,1,1,16'h0400,16'h0105, 0,16'h0000,0,16'h0000, 0);
        cyc("stall_no_write",     16'h0105, 0,1, 1,1,1,16'h0400,16'h0105, 1,16'h0300,0,16'h0000, 0);
        cyc("stall_release",      16'h0000, 0,0, 1,1,1,16'h0400,16'h0105, 0,16'h0000,1,16'h0400, 0);
        cyc("stall_single_upd",   16'h0105, 0,0, 0,0,0,16'h0000,16'h0000, 1,16'h0400,0,16'h0000, 0);
        cyc("ifid_stall_adv",     16'h0000, 1,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("mis_over_stall",     16'h0000, 1,0, 1,1,0,16'h0000,16'h0105, 0,16'h0000,1,16'h0106, 0);
        cyc("flush_ex",           16'h0000, 0,0, 0,0,0,16'h0000,16'h0105, 0,16'h0000,0,16'h0000, 0);
        cyc("flush_id",           16'h0000, 0,0, 0,0,0,16'h0000,16'h0105, 0,16'h0000,0,16'h0000, 0);
        cyc("wrap_setup",         16'h0105, 0,0, 0,0,0,16'h0000,16'h0000, 1,16'h0400,0,16'h0000, 0);
        cyc("fill_e",             16'h0000, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("wrap_redirect",      16'h0000, 0,0, 1,0,0,16'h0000,16'hFFFF, 0,16'h0000,1,16'h0000, 0);
        cyc("pre_reset",          16'h0000, 0,0, 1,0,1,16'h0060,16'h0023, 0,16'h0000,1,16'h0060, 1);
        cyc("in_reset",           16'h0105, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        rst_n = 1'b1;
        cyc("post_reset_jmp",     16'h0105, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);
        cyc("post_reset_br",      16'h0023, 0,0, 0,0,0,16'h0000,16'h0000, 0,16'h0000,0,16'h0000, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
